// File: rtl/vr_udp_tx_arb.sv
// rtl/vr_udp_tx_arb.sv - round-robin arbiter sharing one UDP TX meta/data interface among VR engines
//
// Purpose:
//   Grants the single UDP transmit interface (meta channel + data stream) to
//   one of NUM_SRCS engines at a time. The grant is taken in IDLE, held
//   through the meta handshake and every data flit up to and including the
//   flit with last set, so packets from different engines never interleave.
//   The search starts at prio_q, which moves one past the source that just
//   finished a packet.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   src_arb_meta_val/info     per-source meta request and UDP metadata
//   arb_src_meta_rdy          per-source meta ready (only the granted source)
//   src_arb_data_val/data/
//     last/padbytes           per-source data flit stream
//   arb_src_data_rdy          per-source data ready (only the granted source)
//   arb_to_udp_meta_*         meta channel towards UDP TX, to_udp_arb_meta_rdy back
//   arb_to_udp_data_*         data stream towards UDP TX, to_udp_arb_data_rdy back
//   arb_grant_val/idx         a grant is held / which source holds it

module vr_udp_tx_arb #(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
  parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES),
  parameter int NUM_SRCS       = 2,
  parameter int SRC_W          = $clog2(NUM_SRCS),
  parameter int UDP_INFO_W     = 96
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_SRCS-1:0]                        src_arb_meta_val,
  input  logic [NUM_SRCS-1:0][UDP_INFO_W-1:0]        src_arb_meta_info,
  output logic [NUM_SRCS-1:0]                        arb_src_meta_rdy,
  input  logic [NUM_SRCS-1:0]                        src_arb_data_val,
  input  logic [NUM_SRCS-1:0][NOC_DATA_W-1:0]        src_arb_data,
  input  logic [NUM_SRCS-1:0]                        src_arb_data_last,
  input  logic [NUM_SRCS-1:0][NOC_PADBYTES_W-1:0]    src_arb_data_padbytes,
  output logic [NUM_SRCS-1:0]                        arb_src_data_rdy,
  output logic                                       arb_to_udp_meta_val,
  output logic [UDP_INFO_W-1:0]                      arb_to_udp_meta_info,
  input  logic                                       to_udp_arb_meta_rdy,
  output logic                                       arb_to_udp_data_val,
  output logic [NOC_DATA_W-1:0]                      arb_to_udp_data,
  output logic                                       arb_to_udp_data_last,
  output logic [NOC_PADBYTES_W-1:0]                  arb_to_udp_data_padbytes,
  input  logic                                       to_udp_arb_data_rdy,
  output logic                                       arb_grant_val,
  output logic [SRC_W-1:0]                           arb_grant_idx
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_META = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [SRC_W-1:0] LAST_SRC   = SRC_W'(NUM_SRCS - 1);
  localparam logic [SRC_W:0]   NUM_SRCS_X = (SRC_W + 1)'(NUM_SRCS);

  logic [1:0]       state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] prio_q,  prio_d;

  logic             pick_val;
  logic [SRC_W-1:0] pick_idx;
  logic [SRC_W:0]   cand;
  logic             meta_hs;
  logic             data_hs_last;

  // Round-robin pick. The loop walks the candidates from the farthest back to
  // prio_q itself, so the last hit written is the nearest requester at or
  // after prio_q. cand carries one extra bit so prio_q + i cannot overflow
  // before it is folded back into 0..NUM_SRCS-1 (non-power-of-2 safe).
  always_comb begin
    pick_val = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = NUM_SRCS - 1; i >= 0; i--) begin
      cand = {1'b0, prio_q} + (SRC_W + 1)'(i);
      if (cand >= NUM_SRCS_X) begin
        cand = cand - NUM_SRCS_X;
      end
      if (src_arb_meta_val[cand[SRC_W-1:0]]) begin
        pick_val = 1'b1;
        pick_idx = cand[SRC_W-1:0];
      end
    end
  end

  assign meta_hs      = (state_q == ST_META) && src_arb_meta_val[grant_q] && to_udp_arb_meta_rdy;
  assign data_hs_last = (state_q == ST_DATA) && src_arb_data_val[grant_q] && to_udp_arb_data_rdy
                        && src_arb_data_last[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_val) begin
          grant_d = pick_idx;
          state_d = ST_META;
        end
      end
      ST_META: begin
        if (meta_hs) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_hs_last) begin
          state_d = ST_IDLE;
          prio_d  = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only the granted source ever sees a ready, and only in the phase that
  // matches the channel; everything else is left untouched at its source.
  always_comb begin
    arb_src_meta_rdy    = '0;
    arb_src_data_rdy    = '0;
    arb_to_udp_meta_val = 1'b0;
    arb_to_udp_data_val = 1'b0;
    if (state_q == ST_META) begin
      arb_to_udp_meta_val       = src_arb_meta_val[grant_q];
      arb_src_meta_rdy[grant_q] = to_udp_arb_meta_rdy;
    end
    if (state_q == ST_DATA) begin
      arb_to_udp_data_val       = src_arb_data_val[grant_q];
      arb_src_data_rdy[grant_q] = to_udp_arb_data_rdy;
    end
  end

  // Payload fields follow the grant unconditionally; they only matter while
  // the matching valid is high.
  assign arb_to_udp_meta_info     = src_arb_meta_info[grant_q];
  assign arb_to_udp_data          = src_arb_data[grant_q];
  assign arb_to_udp_data_last     = src_arb_data_last[grant_q];
  assign arb_to_udp_data_padbytes = src_arb_data_padbytes[grant_q];

  assign arb_grant_val = (state_q != ST_IDLE);
  assign arb_grant_idx = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_vr_udp_tx_arb.sv
// tb/tb_vr_udp_tx_arb.sv - self-checking bench for vr_udp_tx_arb
module tb_vr_udp_tx_arb;

  localparam int DW = 512;
  localparam int PW = 6;
  localparam int NS = 2;
  localparam int SW = 1;
  localparam int IW = 96;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS-1:0]         src_arb_meta_val;
  logic [NS-1:0][IW-1:0] src_arb_meta_info;
  logic [NS-1:0]         arb_src_meta_rdy;
  logic [NS-1:0]         src_arb_data_val;
  logic [NS-1:0][DW-1:0] src_arb_data;
  logic [NS-1:0]         src_arb_data_last;
  logic [NS-1:0][PW-1:0] src_arb_data_padbytes;
  logic [NS-1:0]         arb_src_data_rdy;
  logic                  arb_to_udp_meta_val;
  logic [IW-1:0]         arb_to_udp_meta_info;
  logic                  to_udp_arb_meta_rdy;
  logic                  arb_to_udp_data_val;
  logic [DW-1:0]         arb_to_udp_data;
  logic                  arb_to_udp_data_last;
  logic [PW-1:0]         arb_to_udp_data_padbytes;
  logic                  to_udp_arb_data_rdy;
  logic                  arb_grant_val;
  logic [SW-1:0]         arb_grant_idx;

  vr_udp_tx_arb #(
    .NOC_DATA_W(DW), .NUM_SRCS(NS), .UDP_INFO_W(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .src_arb_meta_val(src_arb_meta_val), .src_arb_meta_info(src_arb_meta_info),
    .arb_src_meta_rdy(arb_src_meta_rdy),
    .src_arb_data_val(src_arb_data_val), .src_arb_data(src_arb_data),
    .src_arb_data_last(src_arb_data_last), .src_arb_data_padbytes(src_arb_data_padbytes),
    .arb_src_data_rdy(arb_src_data_rdy),
    .arb_to_udp_meta_val(arb_to_udp_meta_val), .arb_to_udp_meta_info(arb_to_udp_meta_info),
    .to_udp_arb_meta_rdy(to_udp_arb_meta_rdy),
    .arb_to_udp_data_val(arb_to_udp_data_val), .arb_to_udp_data(arb_to_udp_data),
    .arb_to_udp_data_last(arb_to_udp_data_last), .arb_to_udp_data_padbytes(arb_to_udp_data_padbytes),
    .to_udp_arb_data_rdy(to_udp_arb_data_rdy),
    .arb_grant_val(arb_grant_val), .arb_grant_idx(arb_grant_idx)
  );

  typedef struct {
    int src;
    int id;
    int n;
  } pkt_t;

  typedef struct {
    logic [1:0] mv, dv, dl;
    logic       mr, dr;
    logic       gv, gi, omv, odv;
    logic [1:0] smr, sdr;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // source models, scoreboard and sink state
  pkt_t    src_q[NS][$];
  pkt_t    cur[NS];
  int      cur_f[NS];
  bit [NS-1:0] active, meta_pend, s_mhs, s_dhs;
  pkt_t    exp_q[$];
  int      next_id = 1;
  bit      auto_en = 0, freeze = 0, hold_drdy = 0, toggle_en = 0;
  int      tcnt = 0, meta_block = 0;
  int      cyc = 0, mon_f = 0;
  bit      in_pkt = 0;
  bit      gap_en = 0, gap_have = 0;
  int      last_meta = 0;
  int      stall_cyc = 0, stall_bad = 0;

  function automatic logic [IW-1:0] make_info(int s, int id);
    return {32'h0A00_0000 + 32'(s), 32'h0A00_00FF, (s == 1) ? 16'h1234 : 16'h4321, 16'(id)};
  endfunction

  function automatic logic [DW-1:0] make_data(int s, int id, int f);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = {8'(s), 8'(id), 16'(f)};
    return d;
  endfunction

  function automatic logic [PW-1:0] pad_of(int s);
    return (s == 1) ? 6'd63 : 6'd7;
  endfunction

  function automatic vec_t mk(logic [1:0] mv, logic [1:0] dv, logic [1:0] dl, logic mr, logic dr,
                              logic gv, logic gi, logic omv, logic odv, logic [1:0] smr, logic [1:0] sdr);
    vec_t v;
    v.mv = mv; v.dv = dv; v.dl = dl; v.mr = mr; v.dr = dr;
    v.gv = gv; v.gi = gi; v.omv = omv; v.odv = odv; v.smr = smr; v.sdr = sdr;
    return v;
  endfunction

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input int s, input int n);
    pkt_t p;
    p.src = s; p.id = next_id; p.n = n;
    next_id = (next_id + 1) % 256;
    src_q[s].push_back(p);
    exp_q.push_back(p);
  endtask

  task automatic drive_sources();
    for (int s = 0; s < NS; s++) begin
      if (s_mhs[s]) meta_pend[s] = 1'b0;
      if (s_dhs[s]) begin
        if (cur_f[s] == cur[s].n - 1) active[s] = 1'b0;
        else cur_f[s]++;
      end
      if (!active[s] && src_q[s].size() > 0) begin
        cur[s] = src_q[s].pop_front();
        active[s] = 1'b1;
        meta_pend[s] = 1'b1;
        cur_f[s] = 0;
      end
      src_arb_meta_val[s]      = meta_pend[s];
      src_arb_meta_info[s]     = make_info(s, cur[s].id);
      src_arb_data_val[s]      = active[s];
      src_arb_data[s]          = make_data(s, cur[s].id, cur_f[s]);
      src_arb_data_last[s]     = (cur_f[s] == cur[s].n - 1);
      src_arb_data_padbytes[s] = (cur_f[s] == cur[s].n - 1) ? pad_of(s) : '0;
    end
  endtask

  task automatic drive_sink();
    to_udp_arb_meta_rdy = (meta_block == 0);
    if (hold_drdy) begin
      to_udp_arb_data_rdy = 1'b0;
    end else if (toggle_en) begin
      to_udp_arb_data_rdy = ((tcnt % 4) == 0) || ((tcnt % 4) == 3);
      tcnt++;
    end else begin
      to_udp_arb_data_rdy = 1'b1;
    end
  endtask

  task automatic monitor();
    pkt_t p;
    bit ok;
    cyc++;
    s_mhs = src_arb_meta_val & arb_src_meta_rdy;
    s_dhs = src_arb_data_val & arb_src_data_rdy;
    if (arb_to_udp_meta_val && !to_udp_arb_meta_rdy) begin
      stall_cyc++;
      if (meta_block > 0) meta_block--;
      if (exp_q.size() == 0 || arb_to_udp_meta_info != make_info(exp_q[0].src, exp_q[0].id)
          || arb_src_data_rdy != '0 || arb_to_udp_data_val) stall_bad++;
    end
    if (arb_to_udp_meta_val && to_udp_arb_meta_rdy) begin
      if (exp_q.size() == 0 || in_pkt) begin
        check("meta unexpected", 1'b0, 64'(arb_grant_idx), 64'(exp_q.size()));
      end else begin
        p = exp_q[0];
        check("meta info", arb_to_udp_meta_info == make_info(p.src, p.id),
              arb_to_udp_meta_info[63:0], make_info(p.src, p.id));
        check("grant idx", arb_grant_idx == SW'(p.src), 64'(arb_grant_idx), 64'(p.src));
        if (gap_en) begin
          if (gap_have) check("packet period", (cyc - last_meta) == 3, 64'(cyc - last_meta), 64'd3);
          gap_have  = 1'b1;
          last_meta = cyc;
        end
        in_pkt = 1'b1;
        mon_f  = 0;
      end
    end
    if (arb_to_udp_data_val && to_udp_arb_data_rdy) begin
      if (exp_q.size() == 0 || !in_pkt) begin
        check("data unexpected", 1'b0, 64'(arb_to_udp_data[31:0]), 64'(exp_q.size()));
      end else begin
        p  = exp_q[0];
        ok = (arb_to_udp_data == make_data(p.src, p.id, mon_f))
             && (arb_to_udp_data_last == (mon_f == p.n - 1))
             && (!arb_to_udp_data_last || arb_to_udp_data_padbytes == pad_of(p.src));
        check("flit", ok, {arb_to_udp_data_last, arb_to_udp_data_padbytes, arb_to_udp_data[31:0]},
              {(mon_f == p.n - 1), (mon_f == p.n - 1) ? pad_of(p.src) : arb_to_udp_data_padbytes,
               make_data(p.src, p.id, mon_f)[31:0]});
        mon_f++;
        if (mon_f == p.n) begin
          void'(exp_q.pop_front());
          in_pkt = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_en) begin
      if (!freeze) drive_sources();
      drive_sink();
    end
    @(negedge clk);
    if (auto_en) monitor();
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic flush();
    for (int s = 0; s < NS; s++) src_q[s].delete();
    exp_q.delete();
    active = '0; meta_pend = '0; s_mhs = '0; s_dhs = '0;
    src_arb_meta_val = '0; src_arb_data_val = '0; src_arb_data_last = '0;
    in_pkt = 1'b0; mon_f = 0;
  endtask

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;
    vec_t v;
    logic [7:0] act_v, exp_v;

    //           mv     dv     dl     mr    dr    gv    gi    omv   odv   smr    sdr
    vecs[0]  = mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    vecs[1]  = mk(2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    vecs[2]  = mk(2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00);
    vecs[3]  = mk(2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10);
    vecs[4]  = mk(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    vecs[5]  = mk(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
    vecs[6]  = mk(2'b10, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
    vecs[7]  = mk(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    vecs[8]  = mk(2'b11, 2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    vecs[9]  = mk(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00);
    vecs[10] = mk(2'b01, 2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    vecs[11] = mk(2'b01, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10);
    vecs[12] = mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    rst = 1'b1;
    src_arb_meta_val = '0; src_arb_data_val = '0; src_arb_data_last = '0;
    to_udp_arb_meta_rdy = 1'b1; to_udp_arb_data_rdy = 1'b1;
    for (int s = 0; s < NS; s++) begin
      src_arb_meta_info[s]     = make_info(s, 0);
      src_arb_data[s]          = make_data(s, 0, 0);
      src_arb_data_padbytes[s] = pad_of(s);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // cycle-exact table: single src1 packet, simultaneous request, prio wrap,
    // meta backpressure with early data, data backpressure
    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      @(posedge clk);
      #1;
      src_arb_meta_val = v.mv; src_arb_data_val = v.dv; src_arb_data_last = v.dl;
      to_udp_arb_meta_rdy = v.mr; to_udp_arb_data_rdy = v.dr;
      @(negedge clk);
      act_v = {arb_grant_val, arb_grant_idx, arb_to_udp_meta_val, arb_to_udp_data_val,
               arb_src_meta_rdy, arb_src_data_rdy};
      exp_v = {v.gv, v.gi, v.omv, v.odv, v.smr, v.sdr};
      check($sformatf("vec%0d ctrl", i), act_v == exp_v, 64'(act_v), 64'(exp_v));
      if (v.omv)
        check($sformatf("vec%0d info", i), arb_to_udp_meta_info == make_info(int'(v.gi), 0),
              arb_to_udp_meta_info[63:0], make_info(int'(v.gi), 0));
      if (v.odv)
        check($sformatf("vec%0d flit", i),
              arb_to_udp_data == make_data(int'(v.gi), 0, 0) && arb_to_udp_data_last == v.dl[v.gi]
              && arb_to_udp_data_padbytes == pad_of(int'(v.gi)),
              {arb_to_udp_data_last, arb_to_udp_data_padbytes, arb_to_udp_data[31:0]},
              {v.dl[v.gi], pad_of(int'(v.gi)), make_data(int'(v.gi), 0, 0)[31:0]});
    end

    auto_en = 1'b1;

    // simultaneous 2-flit packets: src0 then src1
    send(0, 2); send(1, 2);
    wait_done(60, "simultaneous done");

    // fairness: alternating 1-flit packets, 3 cycles each
    gap_en = 1'b1; gap_have = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(0, 1); send(1, 1);
    end
    wait_done(120, "fairness done");
    gap_en = 1'b0;

    // 4-flit packet with toggling data ready; src1 must wait
    toggle_en = 1'b1; tcnt = 0; bad = 0; k = 0;
    send(0, 4); send(1, 1);
    while (exp_q.size() > 0 && k < 200) begin
      tick();
      k++;
      if (exp_q.size() > 0 && exp_q[0].src == 0 && arb_src_meta_rdy[1]) bad++;
    end
    check("multiflit done", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    check("src1 meta held off", bad == 0, 64'(bad), 64'd0);
    toggle_en = 1'b0;

    // meta backpressure for 5 cycles
    stall_cyc = 0; stall_bad = 0; meta_block = 5;
    send(1, 2);
    wait_done(60, "meta backpressure done");
    check("meta stall cycles", stall_cyc == 5, 64'(stall_cyc), 64'd5);
    check("meta stall stable", stall_bad == 0, 64'(stall_bad), 64'd0);

    // reset mid-packet with prio at 1
    send(0, 1);
    wait_done(30, "pre-reset packet done");
    send(1, 4);
    k = 0;
    while (!(in_pkt && mon_f == 2) && k < 50) begin
      tick();
      k++;
    end
    check("reached flit 2", in_pkt && mon_f == 2, 64'(mon_f), 64'd2);
    hold_drdy = 1'b1;
    tick();
    rst = 1'b1; freeze = 1'b1; hold_drdy = 1'b0;
    tick();
    act_v = {3'b000, arb_grant_val, arb_to_udp_meta_val, arb_to_udp_data_val,
             |arb_src_meta_rdy, |arb_src_data_rdy};
    check("after reset idle", act_v == 8'h00, 64'(act_v), 64'd0);
    rst = 1'b0;
    flush();
    freeze = 1'b0;
    send(0, 1); send(1, 1);
    wait_done(60, "post-reset packets done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vr_udp_tx_arb.md
Name: vr_udp_tx_arb

Overview:
- Shares the single UDP transmit interface (meta channel plus data stream) among NUM_SRCS VR engines, e.g. the setup engine and the request/reply engines.
- Grants one source at a time using round-robin arbitration.
- Holds the grant from meta handshake through the data flit with last asserted, so packets are never interleaved.
- Sits between the VR engines and the UDP TX NoC interface.

Parameters:
- NOC_DATA_W, 512, data flit width in bits.
- NOC_PADBYTES, NOC_DATA_W/8, bytes per flit.
- NOC_PADBYTES_W, $clog2(NOC_PADBYTES), padbytes field width.
- NUM_SRCS, 2, number of requesting engines (>=2).
- SRC_W, $clog2(NUM_SRCS), source index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_arb_meta_val  in  NUM_SRCS  per-source meta valid
- src_arb_meta_info  in  NUM_SRCS x udp_info  per-source UDP metadata
- arb_src_meta_rdy  out  NUM_SRCS  per-source meta ready
- src_arb_data_val  in  NUM_SRCS  per-source data valid
- src_arb_data  in  NUM_SRCS x NOC_DATA_W  per-source data flit
- src_arb_data_last  in  NUM_SRCS  per-source last flit
- src_arb_data_padbytes  in  NUM_SRCS x NOC_PADBYTES_W  per-source padbytes
- arb_src_data_rdy  out  NUM_SRCS  per-source data ready
- arb_to_udp_meta_val  out  1  meta valid to UDP TX
- arb_to_udp_meta_info  out  udp_info  meta to UDP TX
- to_udp_arb_meta_rdy  in  1  UDP TX meta ready
- arb_to_udp_data_val  out  1  data valid to UDP TX
- arb_to_udp_data  out  NOC_DATA_W  data to UDP TX
- arb_to_udp_data_last  out  1  last flit
- arb_to_udp_data_padbytes  out  NOC_PADBYTES_W  padbytes
- to_udp_arb_data_rdy  in  1  UDP TX data ready
- arb_grant_val  out  1  a grant is held (state != IDLE)
- arb_grant_idx  out  SRC_W  currently granted source

Behaviour:
- Registered state: state_reg {IDLE, META, DATA}, grant_reg[SRC_W], prio_reg[SRC_W].
- Reset: state_reg=IDLE, prio_reg=0, grant_reg=0. All val/rdy outputs are 0 in IDLE; info/data outputs are don't-care while their val is 0.
- IDLE:
  - No source sees rdy.
  - If any meta_val is set, grant_reg <= first source with meta_val=1 searching from prio_reg upward with wrap (prio_reg, prio_reg+1, ..., NUM_SRCS-1, 0, ...). state <= META.
  - Selection uses only registered/current meta_val. There is exactly one cycle of arbitration bubble.
- META:
  - arb_to_udp_meta_val = src_arb_meta_val[grant_reg]; info = src_arb_meta_info[grant_reg].
  - arb_src_meta_rdy[grant_reg] = to_udp_arb_meta_rdy; other rdys are 0.
  - On handshake (val&rdy), state <= DATA.
  - Sources must hold val until rdy; dropping val is illegal and stalls here.
- DATA:
  - Pass through the granted source's data/last/padbytes. arb_to_udp_data_val = src_arb_data_val[grant_reg].
  - arb_src_data_rdy[grant_reg] = to_udp_arb_data_rdy; others are 0.
  - On handshake with last=1: state <= IDLE, prio_reg <= (grant_reg==NUM_SRCS-1) ? 0 : grant_reg+1.
  - Handshakes without last stay in DATA. Multi-flit packets are supported, with no flit limit.
- Non-granted sources' meta and data are fully ignored, never consumed, never dropped.
- Minimum per-packet cost: IDLE(1) + META(1) + N data flits. A back-to-back source gets at most one packet before any other pending source is served.
- Data valid from the granted source before the meta handshake is not consumed until DATA.
- Backpressure: any number of rdy=0 cycles in META/DATA holds state, and outputs stay stable from the source.
- Reset mid-packet: returns to IDLE with prio_reg=0 the next cycle. The partial packet is abandoned; sources are reset by the same rst.
- prio_reg arithmetic wraps at NUM_SRCS, not 2^SRC_W (non-power-of-2 NUM_SRCS legal).
- arb_grant_val = (state_reg != IDLE); arb_grant_idx = grant_reg.

Test Plan:
- Single source: src1 meta_val with info(src_port=0x1234), one flit last=1, padbytes=63.
  - IDLE 1 cycle, then meta out with same info, then data out.
  - arb_src_data_rdy[1] pulses once; prio_reg -> 0.
- Simultaneous: src0 and src1 assert meta in the same cycle after reset.
  - Packet from src0 is sent fully, then src1.
  - No flit interleaving; arb_grant_idx 0 then 1.
- Fairness: both sources continuously stream 1-flit packets for 10 packets.
  - Grants alternate 0,1,0,1...
  - Each packet takes 3 cycles with rdy=1.
- Multi-flit with backpressure: src0 sends 4 flits; to_udp_arb_data_rdy toggles 1,0,0,1...
  - All 4 flits arrive in order with last only on flit 4.
  - src1 is held waiting, meta_rdy[1]=0 throughout.
- Meta backpressure: to_udp_arb_meta_rdy=0 for 5 cycles.
  - meta_val held and info stable; no data_rdy until meta handshake.
- Reset in DATA after flit 2 of 4.
  - Next cycle all val/rdy are 0 and arb_grant_val=0.
  - A subsequent src1 request is granted normally.
